// File: rtl/bram_frame_ctrl.sv
// Buffers one frame into a sync-read BRAM, then streams it back forward or reversed.
// Reads reach out_valid 3 cycles after issue; a 4-credit FIFO absorbs out_ready stalls.
module bram_frame_ctrl #(
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rd_rev,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy_rd,
  output logic              frame_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(FRAME_LEN);
  localparam int FIFO_D = 4;

  typedef enum logic {ST_WRITE = 1'b0, ST_READ = 1'b1} state_t;

  state_t            state_q;
  logic              in_ready_q, rev_q, rd_p1_q, rd_p2_q;
  logic              bram_we_q, bram_en_q, frame_done_q;
  logic [ADDR_W-1:0] wr_cnt_q, popped_q, rd_addr_q, bram_addr_q;
  logic [CNT_W-1:0]  issued_q;
  logic [DATA_W-1:0] bram_din_q;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_D];
  logic [1:0]        fifo_wp_q, fifo_rp_q;
  logic [2:0]        fifo_cnt_q;

  logic              wr_hs, issue, push, pop;
  logic [2:0]        credit_used;
  logic [ADDR_W-1:0] rd_addr_d;

  assign wr_hs       = (state_q == ST_WRITE) && in_valid && in_ready_q;
  // Words already in the FIFO plus reads still in the BRAM pipe must never exceed depth.
  assign credit_used = fifo_cnt_q + {2'b00, rd_p1_q} + {2'b00, rd_p2_q};
  assign issue       = (state_q == ST_READ) && (issued_q < LEN_C) && (credit_used < 3'd4);
  assign push        = rd_p2_q;
  assign pop         = out_valid && out_ready;
  assign rd_addr_d   = rev_q ? (rd_addr_q - ADDR_W'(1)) : (rd_addr_q + ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WRITE;
      in_ready_q   <= 1'b0;
      rev_q        <= 1'b0;
      rd_p1_q      <= 1'b0;
      rd_p2_q      <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wr_cnt_q     <= '0;
      popped_q     <= '0;
      rd_addr_q    <= '0;
      bram_addr_q  <= '0;
      issued_q     <= '0;
      bram_din_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_en_q    <= 1'b0;
      rd_p1_q      <= issue;
      rd_p2_q      <= rd_p1_q;
      case (state_q)
        ST_WRITE: begin
          in_ready_q <= 1'b1;
          if (wr_hs) begin
            bram_we_q   <= 1'b1;
            bram_en_q   <= 1'b1;
            bram_addr_q <= wr_cnt_q;
            bram_din_q  <= in_data;
            if (wr_cnt_q == LAST_A) begin
              state_q    <= ST_READ;
              in_ready_q <= 1'b0;
              wr_cnt_q   <= '0;
              rev_q      <= rd_rev;
              rd_addr_q  <= rd_rev ? LAST_A : '0;
            end else begin
              wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            bram_en_q   <= 1'b1;
            bram_addr_q <= rd_addr_q;
            rd_addr_q   <= rd_addr_d;
            issued_q    <= issued_q + CNT_W'(1);
          end
          if (pop) begin
            if (popped_q == LAST_A) begin
              state_q      <= ST_WRITE;
              in_ready_q   <= 1'b1;
              frame_done_q <= 1'b1;
              popped_q     <= '0;
              issued_q     <= '0;
            end else begin
              popped_q <= popped_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= ST_WRITE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[fifo_wp_q] <= bram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) fifo_wp_q <= fifo_wp_q + 2'd1;
      if (pop)  fifo_rp_q <= fifo_rp_q + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (fifo_cnt_q != 3'd0);
  assign out_data   = out_valid ? fifo_mem_q[fifo_rp_q] : '0;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign bram_we    = bram_we_q;
  assign bram_en    = bram_en_q;
  assign busy_rd    = (state_q == ST_READ);
  assign frame_done = frame_done_q;

endmodule

// File: doc/bram_frame_ctrl.md
Name: bram_frame_ctrl

Overview:
- Frame buffer controller placed directly in front of the matrix_multip BRAM core in the NB-LDPC datapath.
- Accepts a valid/ready stream of 20-bit symbol words and writes one frame of FRAME_LEN words into the BRAM at sequential addresses.
- Then reads the frame back out (forward or reversed order) as a valid/ready stream for the check-node stage.
- Absorbs the BRAM's 1-cycle synchronous read latency and downstream backpressure with a 4-entry output FIFO.

Parameters:
- DATA_W, 20, word width; matches the BRAM data_in/data_out.
- ADDR_W, 12, BRAM address width.
- FRAME_LEN, 96, words per frame; legal range 2..2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts input.
- rd_rev  in  1  read order select: 0 = ascending addresses, 1 = descending. Sampled on the WRITE->READ transition.
- out_data  out  DATA_W  output word (FIFO head).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- bram_addr  out  ADDR_W  to BRAM addr; registered.
- bram_din  out  DATA_W  to BRAM data_in; registered.
- bram_we  out  1  to BRAM wr_en; registered.
- bram_en  out  1  to BRAM core_en; registered.
- bram_dout  in  DATA_W  from BRAM data_out. Valid the cycle after an enabled read address was presented.
- busy_rd  out  1  high while in READ.
- frame_done  out  1  one-cycle pulse when the last word of a frame is consumed.

Behaviour:
- Reset (async, rst_n=0):
  - state=WRITE; all counters 0; FIFO empty.
  - in_ready=0 while in reset; in_ready=1 from the first cycle after release.
  - out_valid=0, out_data=0, bram_addr=0, bram_din=0, bram_we=0, bram_en=0, busy_rd=0, frame_done=0.
  - BRAM contents are not cleared.
- WRITE state:
  - in_ready=1.
  - Handshake = in_valid & in_ready in cycle N -> cycle N+1 drives bram_we=1, bram_en=1, bram_addr=wr_cnt, bram_din=in_data.
  - wr_cnt increments per handshake.
  - With no handshake, bram_we=0 and bram_en=0 on the next cycle.
  - The handshake with wr_cnt=FRAME_LEN-1 moves the state to READ on the same edge, clears wr_cnt and latches rd_rev. in_ready=0 from the next cycle.
- READ state:
  - in_ready=0; in_valid is ignored and no words are lost or accepted.
  - Issue a read when issued<FRAME_LEN and fifo_count+inflight<4. inflight = reads issued but not yet captured, 0..2.
  - Issue in cycle N -> bram_addr/bram_en=1/bram_we=0 registered for cycle N+1; bram_dout is captured into the FIFO at the end of cycle N+2.
  - Result: out_valid no earlier than cycle N+3.
  - Address sequence: 0..FRAME_LEN-1 if rd_rev=0, else FRAME_LEN-1 down to 0. No wrap beyond the frame.
  - With out_ready held at 1: one word per cycle sustained; first out_valid 3 cycles after entering READ.
- FIFO:
  - Depth 4, first-word-fall-through.
  - out_data/out_valid reflect the head.
  - A pop on out_valid & out_ready.
  - A simultaneous capture and pop leaves the count unchanged.
  - The credit rule guarantees the FIFO never overflows.
- out_ready=0: issues stop once credit is exhausted; out_data is held stable while out_valid=1 and not accepted.
- Pop of the FRAME_LEN-th output word:
  - frame_done=1 for the next cycle.
  - State returns to WRITE; busy_rd=0; in_ready=1 from the next cycle.
  - Counters cleared.
- bram_en=0 in any cycle with no write or read issued.
- Reset asserted mid-frame aborts immediately to the reset state; the partial frame is discarded.

Test Plan:
- FRAME_LEN=4, write 10,20,30,40 with in_valid steady -> bram_we pulses at addr 0..3 one cycle after each handshake; in_ready=0 after the 4th word.
- Same frame, rd_rev=0, out_ready=1 -> out_data 10,20,30,40 on consecutive cycles, first 3 cycles after the state change; frame_done pulses once, then in_ready=1.
- rd_rev=1 with data 1,2,3,4 -> output 4,3,2,1; bram_addr sequence 3,2,1,0.
- out_ready toggled 1-of-3 cycles, FRAME_LEN=8 -> all 8 words in order with no duplicates/drops; FIFO count never >4; out_data stable while stalled.
- in_valid held high during READ -> no extra bram_we and next frame unaffected; gapped in_valid in WRITE -> addresses stay contiguous.
- rst_n pulsed low after 2 writes of a frame -> outputs at reset values immediately; the next 4 writes land at addr 0..3.
